// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4 memory responder.
//   RESP_*  : AXI response codes returned on BRESP / RRESP
//   BURST_* : AxBURST encodings (WRAP is accepted but answered as an error)
//   w_state_t / r_state_t : write and read channel FSM encodings
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_mem_slave_addr_gen.sv
// Per-beat address helper for one AXI direction.
//   addr      : current (possibly unaligned) beat address
//   burst     : AxBURST of the active burst
//   next_addr : address of the following beat (FIXED holds, INCR/WRAP step one beat)
//   in_range  : aligned address falls inside the RAM window
//   word_idx  : RAM word index of the aligned address (meaningful only when in_range)
module axi_mem_slave_addr_gen
    import axi_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hC000_0000,
    parameter int                DEPTH     = 1024
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic [1:0]               burst,
    output logic [ADDR_W-1:0]        next_addr,
    output logic                     in_range,
    output logic [$clog2(DEPTH)-1:0] word_idx
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    // One extra bit so BASE_ADDR + window cannot wrap at the top of the space.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(DEPTH * BYTES);

    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] offset;

    always_comb begin
        aligned  = addr & ~ADDR_W'(BYTES - 1);
        offset   = aligned - BASE_ADDR;
        in_range = ({1'b0, aligned} >= WIN_LO) && ({1'b0, aligned} < WIN_HI);
        word_idx = IDX_W'(offset >> OFF_W);
        // WRAP is deliberately stepped like INCR; the error is reported elsewhere.
        next_addr = (burst == BURST_FIXED) ? addr : aligned + ADDR_W'(BYTES);
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder backed by a word-addressed RAM at BASE_ADDR.
// Accepts one write burst and one read burst at a time (FIXED/INCR; WRAP is
// answered SLVERR), returns DECERR for beats outside the window.
// Ports: ACLK/ARESET (sync, active high), AXI4 slave channels AW, W, B, AR, R.
// Build option: AXI_MEM_SLAVE_WSTRB_EN -- honour S_WSTRB per byte; when
// undefined every accepted beat writes the whole word.
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write burst address
// W_DATA | WREADY high, storing beats until WLAST
// W_RESP | BVALID high with the accumulated response, waiting for BREADY
// R_IDLE | ARREADY high, waiting for a read burst address
// R_DATA | RVALID high, current beat held until RREADY
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hC000_0000,
    parameter int                DEPTH     = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_W-1:0]     S_AWADDR,
    input  logic [7:0]            S_AWLEN,
    input  logic [1:0]            S_AWBURST,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [DATA_W-1:0]     S_WDATA,
    input  logic [DATA_W/8-1:0]   S_WSTRB,
    input  logic                  S_WLAST,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic                  S_BREADY,
    input  logic [ADDR_W-1:0]     S_ARADDR,
    input  logic [7:0]            S_ARLEN,
    input  logic [1:0]            S_ARBURST,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    output logic [DATA_W-1:0]     S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RLAST,
    output logic                  S_RVALID,
    input  logic                  S_RREADY
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t w_state, w_state_nx;
    r_state_t r_state, r_state_nx;

    logic [ADDR_W-1:0] w_addr, w_next;
    logic [7:0]        w_len, w_cnt;
    logic [1:0]        w_burst;
    logic              w_over, w_decerr, w_slverr, w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              aw_hs, w_hs, w_do_write;

    logic [ADDR_W-1:0] r_addr, r_next, r_cur_addr;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst, r_cur_burst;
    logic              r_in_range;
    logic [IDX_W-1:0]  r_idx;
    logic              ar_hs, r_hs, r_load;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    assign aw_hs      = (w_state == W_IDLE) && S_AWVALID;
    assign w_hs       = (w_state == W_DATA) && S_WVALID;
    // Beats past AWLEN (w_over) are swallowed without touching the RAM.
    assign w_do_write = w_hs && w_in_range && !w_over && !ARESET;

    // Beat 0 is fetched straight from the AR bus so RVALID rises the cycle after AR.
    assign ar_hs       = (r_state == R_IDLE) && S_ARVALID;
    assign r_hs        = (r_state == R_DATA) && S_RREADY;
    assign r_load      = ar_hs || (r_hs && !rlast_q);
    assign r_cur_addr  = (r_state == R_IDLE) ? S_ARADDR  : r_addr;
    assign r_cur_burst = (r_state == R_IDLE) ? S_ARBURST : r_burst;

    axi_mem_slave_addr_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)
    ) u_wr_addr (
        .addr(w_addr), .burst(w_burst),
        .next_addr(w_next), .in_range(w_in_range), .word_idx(w_idx)
    );

    axi_mem_slave_addr_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)
    ) u_rd_addr (
        .addr(r_cur_addr), .burst(r_cur_burst),
        .next_addr(r_next), .in_range(r_in_range), .word_idx(r_idx)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        r_state_nx = r_state;
        S_AWREADY  = 1'b0;
        S_WREADY   = 1'b0;
        S_BVALID   = 1'b0;
        S_ARREADY  = 1'b0;
        S_RVALID   = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AWREADY = 1'b1;
                if (S_AWVALID) w_state_nx = W_DATA;
            end
            W_DATA: begin
                S_WREADY = 1'b1;
                if (S_WVALID && S_WLAST) w_state_nx = W_RESP;
            end
            W_RESP: begin
                S_BVALID = 1'b1;
                if (S_BREADY) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
        case (r_state)
            R_IDLE: begin
                S_ARREADY = 1'b1;
                if (S_ARVALID) r_state_nx = R_DATA;
            end
            R_DATA: begin
                S_RVALID = 1'b1;
                if (S_RREADY && rlast_q) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_addr   <= '0;
            w_len    <= '0;
            w_burst  <= '0;
            w_cnt    <= '0;
            w_over   <= 1'b0;
            w_decerr <= 1'b0;
            w_slverr <= 1'b0;
        end else if (aw_hs) begin
            w_addr   <= S_AWADDR;
            w_len    <= S_AWLEN;
            w_burst  <= S_AWBURST;
            w_cnt    <= '0;
            w_over   <= 1'b0;
            w_decerr <= 1'b0;
            w_slverr <= (S_AWBURST == BURST_WRAP);
        end else if (w_hs) begin
            w_addr <= w_next;
            if (!w_in_range) w_decerr <= 1'b1;
            // Either side of a length mismatch: early WLAST or beats past AWLEN.
            if (w_over || (S_WLAST && (w_cnt != w_len))) w_slverr <= 1'b1;
            if (!w_over) begin
                if ((w_cnt == w_len) && !S_WLAST) w_over <= 1'b1;
                w_cnt <= w_cnt + 8'd1;
            end
        end
    end

    assign S_BRESP = w_decerr ? RESP_DECERR : (w_slverr ? RESP_SLVERR : RESP_OKAY);

    always_ff @(posedge ACLK) begin
        if (w_do_write) begin
`ifdef AXI_MEM_SLAVE_WSTRB_EN
            for (int b = 0; b < DATA_W/8; b++) begin
                if (S_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_WDATA[8*b +: 8];
            end
`else
            mem[w_idx] <= S_WDATA;
`endif
        end
    end

`ifndef AXI_MEM_SLAVE_WSTRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^S_WSTRB;
`endif

    // The RAM read shares the edge with the write port, so a same-word
    // read and write returns the previous contents.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_len   <= S_ARLEN;
                r_burst <= S_ARBURST;
                r_cnt   <= '0;
                rlast_q <= (S_ARLEN == 8'd0);
            end else if (r_hs) begin
                r_cnt   <= r_cnt + 8'd1;
                rlast_q <= !rlast_q && ((r_cnt + 8'd1) == r_len);
            end
            if (r_load) begin
                r_addr  <= r_next;
                rdata_q <= r_in_range ? mem[r_idx] : '0;
                rresp_q <= !r_in_range ? RESP_DECERR :
                           ((r_cur_burst == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY);
            end
        end
    end

    assign S_RDATA = rdata_q;
    assign S_RRESP = rresp_q;
    assign S_RLAST = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
    import axi_pkg::*;

    localparam logic [31:0] BASE  = 32'hC000_0000;
    localparam logic [31:0] LIMIT = 32'hC000_1000;

    logic        ACLK, ARESET;
    logic [31:0] S_AWADDR, S_WDATA, S_ARADDR, S_RDATA;
    logic [7:0]  S_AWLEN, S_ARLEN;
    logic [1:0]  S_AWBURST, S_ARBURST, S_BRESP, S_RRESP;
    logic [3:0]  S_WSTRB;
    logic        S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic        S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY;

    axi_mem_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWBURST(S_AWBURST),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARBURST(S_ARBURST),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      exp_r[$];
    logic [31:0] model_mem [int];
    logic [31:0] wq[$];
    logic [31:0] rd_got[$];
    logic [1:0]  exp_bresp;
    logic [1:0]  bresp_got;
    int          n_cmp = 0;
    int          n_err = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        return (a >= BASE) && (a < LIMIT);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [1:0] burst, input int i);
        logic [31:0] a;
        a = start & ~32'h3;
        return (burst == BURST_FIXED) ? a : a + 32'(4 * i);
    endfunction

    function automatic int key_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Model of a write burst of wq.size() beats: updates the memory image and
    // sets the response the bench expects on B.
    task automatic model_write(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] strb);
        logic dec, slv;
        logic [31:0] a, w;
        dec = 1'b0;
        slv = (burst == BURST_WRAP) || (wq.size() != int'(len) + 1);
        for (int i = 0; i < wq.size(); i++) begin
            a = beat_addr(addr, burst, i);
            if (!in_win(a)) dec = 1'b1;
            else if (i <= int'(len)) begin
`ifdef AXI_MEM_SLAVE_WSTRB_EN
                w = model_mem.exists(key_of(a)) ? model_mem[key_of(a)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (strb[b]) w[8*b +: 8] = wq[i][8*b +: 8];
`else
                w = wq[i];
`endif
                model_mem[key_of(a)] = w;
            end
        end
        exp_bresp = dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
    endtask

    task automatic model_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        rbeat_t e;
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, i);
            if (in_win(a)) begin
                e.data = model_mem.exists(key_of(a)) ? model_mem[key_of(a)] : 32'hx;
                e.resp = (burst == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                e.data = 32'h0;
                e.resp = RESP_DECERR;
            end
            e.last = (i == int'(len));
            exp_r.push_back(e);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (S_RVALID) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected_beat", 64'(S_RVALID), 64'(0));
                end else begin
                    check("r_data", 64'(S_RDATA), 64'(exp_r[0].data));
                    check("r_resp", 64'(S_RRESP), 64'(exp_r[0].resp));
                    check("r_last", 64'(S_RLAST), 64'(exp_r[0].last));
                    if (S_RREADY) void'(exp_r.pop_front());
                end
            end
            if (S_BVALID) check("b_resp", 64'(S_BRESP), 64'(exp_bresp));
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb);
        int t;
        model_write(addr, len, burst, strb);
        S_AWADDR = addr; S_AWLEN = len; S_AWBURST = burst; S_AWVALID = 1'b1;
        t = 0;
        while (!S_AWREADY && t < 50) begin @(posedge ACLK); #1; t++; end
        check("aw_ready_wait", 64'(S_AWREADY), 64'(1));
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0;
        for (int i = 0; i < wq.size(); i++) begin
            S_WDATA = wq[i]; S_WSTRB = strb; S_WLAST = (i == wq.size() - 1); S_WVALID = 1'b1;
            t = 0;
            while (!S_WREADY && t < 50) begin @(posedge ACLK); #1; t++; end
            check("w_ready_wait", 64'(S_WREADY), 64'(1));
            @(posedge ACLK); #1;
        end
        S_WVALID = 1'b0; S_WLAST = 1'b0;
        t = 0;
        while (!S_BVALID && t < 50) begin @(posedge ACLK); #1; t++; end
        check("b_valid_wait", 64'(S_BVALID), 64'(1));
        bresp_got = S_BRESP;
        S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;
        check("b_valid_after_b", 64'(S_BVALID), 64'(0));
        check("aw_ready_after_b", 64'(S_AWREADY), 64'(1));
    endtask

    // mode 0: RREADY always high; mode 1: RREADY pattern 1,0,0,1,0,0...
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int mode);
        int t, k;
        logic done;
        model_read(addr, len, burst);
        rd_got.delete();
        S_ARADDR = addr; S_ARLEN = len; S_ARBURST = burst; S_ARVALID = 1'b1;
        t = 0;
        while (!S_ARREADY && t < 50) begin @(posedge ACLK); #1; t++; end
        check("ar_ready_wait", 64'(S_ARREADY), 64'(1));
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        check("rvalid_latency", 64'(S_RVALID), 64'(1));
        k = 0; done = 1'b0;
        while (!done && k < 300) begin
            S_RREADY = (mode == 0) ? 1'b1 : (k % 3 == 0);
            if (S_RVALID && S_RREADY) begin
                rd_got.push_back(S_RDATA);
                if (S_RLAST) done = 1'b1;
            end
            k++;
            @(posedge ACLK); #1;
        end
        S_RREADY = 1'b0;
        check("read_done", 64'(done), 64'(1));
        check("rvalid_after_last", 64'(S_RVALID), 64'(0));
        check("arready_after_last", 64'(S_ARREADY), 64'(1));
        check("read_beats_left", 64'(exp_r.size()), 64'(0));
        check("read_beat_count", 64'(rd_got.size()), 64'(int'(len) + 1));
    endtask

    initial begin
        int t;
        ARESET = 1'b1;
        S_AWADDR = '0; S_AWLEN = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
        S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0; S_BREADY = 1'b0;
        S_ARADDR = '0; S_ARLEN = '0; S_ARBURST = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
        exp_bresp = RESP_OKAY;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;

        check("rst_awready", 64'(S_AWREADY), 64'(1));
        check("rst_arready", 64'(S_ARREADY), 64'(1));
        check("rst_wready",  64'(S_WREADY),  64'(0));
        check("rst_bvalid",  64'(S_BVALID),  64'(0));
        check("rst_bresp",   64'(S_BRESP),   64'(0));
        check("rst_rvalid",  64'(S_RVALID),  64'(0));
        check("rst_rlast",   64'(S_RLAST),   64'(0));
        check("rst_rresp",   64'(S_RRESP),   64'(0));
        check("rst_rdata",   64'(S_RDATA),   64'(0));

        // Single beat write/read
        wq = '{32'hDEAD_BEEF};
        do_write(32'hC000_0000, 8'd0, BURST_INCR, 4'hF);
        check("t1_bresp_lit", 64'(bresp_got), 64'(2'b00));
        do_read(32'hC000_0000, 8'd0, BURST_INCR, 0);
        check("t1_rdata_lit", 64'(rd_got[0]), 64'(32'hDEAD_BEEF));

        // Eight beat INCR
        wq = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        do_write(32'hC000_0010, 8'd7, BURST_INCR, 4'hF);
        check("t2_bresp_lit", 64'(bresp_got), 64'(2'b00));
        do_read(32'hC000_0010, 8'd7, BURST_INCR, 0);
        for (int i = 0; i < 8; i++) check("t2_rdata_lit", 64'(rd_got[i]), 64'((i + 1) * 17));

        // Out of window
        wq = '{32'h1234_5678};
        do_write(32'hD000_0000, 8'd0, BURST_INCR, 4'hF);
        check("t3_bresp_lit", 64'(bresp_got), 64'(2'b11));
        do_read(32'hD000_0000, 8'd0, BURST_INCR, 0);
        check("t3_rdata_lit", 64'(rd_got[0]), 64'(0));

        // Stalled read
        do_read(32'hC000_0010, 8'd3, BURST_INCR, 1);
        check("t4_rdata3_lit", 64'(rd_got[3]), 64'(32'h44));

        // Early WLAST over a pre-filled region
        wq = '{32'h0, 32'h1, 32'h2, 32'h3};
        do_write(32'hC000_0300, 8'd3, BURST_INCR, 4'hF);
        wq = '{32'hA0, 32'hA1};
        do_write(32'hC000_0300, 8'd3, BURST_INCR, 4'hF);
        check("t5_bresp_lit", 64'(bresp_got), 64'(2'b10));
        do_read(32'hC000_0300, 8'd3, BURST_INCR, 0);
        check("t5_beat2_kept_lit", 64'(rd_got[2]), 64'(32'h2));

        // Beats past AWLEN are dropped
        wq = '{32'h55, 32'h66};
        do_write(32'hC000_0400, 8'd1, BURST_INCR, 4'hF);
        wq = '{32'hE0, 32'hE1};
        do_write(32'hC000_0400, 8'd0, BURST_INCR, 4'hF);
        check("t6_bresp_lit", 64'(bresp_got), 64'(2'b10));
        do_read(32'hC000_0400, 8'd1, BURST_INCR, 0);

        // Window boundary: last word in, next word out
        wq = '{32'hF1, 32'hF2};
        do_write(32'hC000_0FFC, 8'd1, BURST_INCR, 4'hF);
        check("t7_bresp_lit", 64'(bresp_got), 64'(2'b11));
        do_read(32'hC000_0FFC, 8'd1, BURST_INCR, 0);

        // WRAP answered SLVERR, FIXED holds the address
        wq = '{32'hB0, 32'hB1};
        do_write(32'hC000_0500, 8'd1, BURST_WRAP, 4'hF);
        do_read(32'hC000_0500, 8'd1, BURST_WRAP, 0);
        wq = '{32'hC1, 32'hC2, 32'hC3};
        do_write(32'hC000_0600, 8'd2, BURST_FIXED, 4'hF);
        do_read(32'hC000_0600, 8'd1, BURST_FIXED, 0);
        check("t8_fixed_lit", 64'(rd_got[1]), 64'(32'hC3));

        // Reset in the middle of a read burst
        model_read(32'hC000_0010, 8'd7, BURST_INCR);
        S_ARADDR = 32'hC000_0010; S_ARLEN = 8'd7; S_ARBURST = BURST_INCR; S_ARVALID = 1'b1;
        t = 0;
        while (!S_ARREADY && t < 50) begin @(posedge ACLK); #1; t++; end
        check("t9_ar_ready_wait", 64'(S_ARREADY), 64'(1));
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0; S_RREADY = 1'b1;
        repeat (2) begin @(posedge ACLK); #1; end
        ARESET = 1'b1; S_RREADY = 1'b0;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        exp_r.delete();
        check("t9_rvalid_after_rst", 64'(S_RVALID), 64'(0));
        check("t9_arready_after_rst", 64'(S_ARREADY), 64'(1));
        check("t9_rlast_after_rst", 64'(S_RLAST), 64'(0));
        exp_bresp = RESP_OKAY;
        do_read(32'hC000_0010, 8'd7, BURST_INCR, 0);

        // Byte strobes
        wq = '{32'h1122_3344};
        do_write(32'hC000_0200, 8'd0, BURST_INCR, 4'hF);
        wq = '{32'hAABB_CCDD};
        do_write(32'hC000_0200, 8'd0, BURST_INCR, 4'b0011);
        do_read(32'hC000_0200, 8'd0, BURST_INCR, 0);
`ifdef AXI_MEM_SLAVE_WSTRB_EN
        check("t10_strobe_lit", 64'(rd_got[0]), 64'(32'h1122_CCDD));
`else
        check("t10_strobe_lit", 64'(rd_got[0]), 64'(32'hAABB_CCDD));
`endif

        repeat (3) @(posedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
